// File: rtl/stutter_scheduler.sv
// -----------------------------------------------------------------------------
// stutter_scheduler
//
// Decides, cycle by cycle, which of two code blocks (source and target) may
// advance and which must stutter (hold its state). The scheduler is a Moore
// machine: all outputs come from registered state, except for the finish
// overrides, which act combinationally so that a finished block stops at once.
//
// Ports
//   clk         in   system clock, all state changes on its rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   level, 1 = input-latch phase done, blocks may run
//   change      in   request to swap which block advances
//   align       in   request that both blocks advance together
//   fin_src     in   source block finished (sticky)
//   fin_tar     in   target block finished (sticky)
//   stut_src    out  1 = source block holds state this cycle
//   stut_tar    out  1 = target block holds state this cycle
//   forced      out  1 = current BOTH cycle was entered by the fairness rule
//   sched_state out  IDLE=0, BOTH=1, SRC_ONLY=2, TAR_ONLY=3, DONE=4
//
// Parameters
//   MAX_STALL   longest run of one-sided cycles before both blocks are
//               forced to advance together (1 .. 2**CNT_W-1)
//   CNT_W       width of the stall counter
//
// Configuration macro
//   STUTTER_FAIRNESS_EN  when defined, the stall counter and the fairness rule
//                        are built; otherwise one-sided states may persist
//                        indefinitely and forced is tied to 0.
// -----------------------------------------------------------------------------
module stutter_scheduler #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       change,
  input  logic       align,
  input  logic       fin_src,
  input  logic       fin_tar,
  output logic       stut_src,
  output logic       stut_tar,
  output logic       forced,
  output logic [2:0] sched_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BOTH = 3'd1;
  localparam logic [2:0] S_SRC  = 3'd2;
  localparam logic [2:0] S_TAR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Reject parameter sets where the counter could never reach MAX_STALL-1.
  if (MAX_STALL < 1 || MAX_STALL > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("stutter_scheduler: MAX_STALL must be in 1..2**CNT_W-1");
  end

  logic [2:0] r_state;
  logic [2:0] w_nominal_state;
  logic [2:0] w_next_state;
  logic       w_next_forced;
  logic       w_stut_src_base;
  logic       w_stut_tar_base;

  // Next state from the request inputs alone, before the fairness rule.
  always_comb begin
    w_nominal_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nominal_state = S_BOTH;
        end else begin
          w_nominal_state = S_IDLE;
        end
      end
      S_BOTH, S_SRC, S_TAR: begin
        if (fin_src && fin_tar) begin
          w_nominal_state = S_DONE;
        end else if (align) begin
          // align outranks change; a simultaneous change is simply dropped
          w_nominal_state = S_BOTH;
        end else if (change) begin
          if (r_state == S_SRC) begin
            w_nominal_state = S_TAR;
          end else begin
            // BOTH and TAR_ONLY both move to SRC_ONLY on change
            w_nominal_state = S_SRC;
          end
        end else begin
          w_nominal_state = r_state;
        end
      end
      S_DONE: begin
        w_nominal_state = S_DONE;
      end
      default: begin
        w_nominal_state = S_IDLE;
      end
    endcase
  end

`ifdef STUTTER_FAIRNESS_EN
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MAX_STALL - 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_next_stall_cnt;
  logic             r_forced;
  logic             w_one_sided;

  assign w_one_sided = (r_state == S_SRC) || (r_state == S_TAR);

  // Fairness: a one-sided state that would persist past its budget is
  // replaced by a forced BOTH cycle.
  always_comb begin
    w_next_state  = w_nominal_state;
    w_next_forced = 1'b0;
    if (w_one_sided && (r_stall_cnt == STALL_LAST) &&
        (w_nominal_state == r_state)) begin
      w_next_state  = S_BOTH;
      w_next_forced = 1'b1;
    end else begin
      w_next_state  = w_nominal_state;
      w_next_forced = 1'b0;
    end
  end

  // The counter only survives when staying in the same one-sided state;
  // entering BOTH, swapping sides, IDLE and DONE all clear it.
  always_comb begin
    w_next_stall_cnt = {CNT_W{1'b0}};
    if (w_one_sided && (w_next_state == r_state)) begin
      if (&r_stall_cnt) begin
        w_next_stall_cnt = r_stall_cnt;
      end else begin
        w_next_stall_cnt = r_stall_cnt + CNT_W'(1);
      end
    end else begin
      w_next_stall_cnt = {CNT_W{1'b0}};
    end
  end

  // Stall counter and forced-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_forced    <= 1'b0;
    end else begin
      r_stall_cnt <= w_next_stall_cnt;
      r_forced    <= w_next_forced;
    end
  end

  assign forced = r_forced;
`else
  // Without the fairness rule the requests alone pick the next state.
  always_comb begin
    w_next_state  = w_nominal_state;
    w_next_forced = 1'b0;
  end

  assign forced = w_next_forced & 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stutter decode from registered state.
  always_comb begin
    w_stut_src_base = 1'b1;
    w_stut_tar_base = 1'b1;
    case (r_state)
      S_BOTH: begin
        w_stut_src_base = 1'b0;
        w_stut_tar_base = 1'b0;
      end
      S_SRC: begin
        w_stut_src_base = 1'b0;
        w_stut_tar_base = 1'b1;
      end
      S_TAR: begin
        w_stut_src_base = 1'b1;
        w_stut_tar_base = 1'b0;
      end
      default: begin
        // IDLE, DONE and unused encodings hold both blocks
        w_stut_src_base = 1'b1;
        w_stut_tar_base = 1'b1;
      end
    endcase
  end

  // A finished block is held immediately, without waiting for a clock edge.
  assign stut_src    = w_stut_src_base | fin_src;
  assign stut_tar    = w_stut_tar_base | fin_tar;
  assign sched_state = r_state;

endmodule

// File: tb/tb_stutter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_stutter_scheduler
//
// Directed bench for stutter_scheduler with default parameters
// (MAX_STALL=3, CNT_W=2). Each step pushes the expected output tuple
// {sched_state, stut_src, stut_tar, forced} into a scoreboard queue; the
// tuple is popped and compared once the DUT has produced that output.
// Fairness expectations follow STUTTER_FAIRNESS_EN.
// -----------------------------------------------------------------------------
module tb_stutter_scheduler;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] BOTH = 3'd1;
  localparam logic [2:0] SRC  = 3'd2;
  localparam logic [2:0] TAR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       change;
  logic       align;
  logic       fin_src;
  logic       fin_tar;
  logic       stut_src;
  logic       stut_tar;
  logic       forced;
  logic [2:0] sched_state;

  int errors;
  int checks;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  stutter_scheduler #(
    .MAX_STALL(3),
    .CNT_W    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .change     (change),
    .align      (align),
    .fin_src    (fin_src),
    .fin_tar    (fin_tar),
    .stut_src   (stut_src),
    .stut_tar   (stut_tar),
    .forced     (forced),
    .sched_state(sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [2:0] st,
                            input logic s, input logic t, input logic f);
    exp_q.push_back({st, s, t, f});
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    logic [5:0] obs;
    logic [5:0] e;
    string      tg;
    obs = {sched_state, stut_src, stut_tar, forced};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
    end else begin
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed state=%0d src=%b tar=%b forced=%b expected state=%0d src=%b tar=%b forced=%b",
               tg, obs[5:3], obs[2], obs[1], obs[0], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Check outputs that must follow inputs without a clock edge.
  task automatic now_chk(input string tag, input logic [2:0] st,
                         input logic s, input logic t, input logic f);
    expect_out(tag, st, s, t, f);
    #1;
    compare_out();
  endtask

  // Let one rising edge happen with the current inputs, then check.
  task automatic step(input string tag, input logic [2:0] st,
                      input logic s, input logic t, input logic f);
    expect_out(tag, st, s, t, f);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    change  = 1'b0;
    align   = 1'b0;
    fin_src = 1'b0;
    fin_tar = 1'b0;

    // Reset values, held two cycles, then start on cycle 3
    #2;
    now_chk("reset_async", IDLE, 1'b1, 1'b1, 1'b0);
    step("reset_hold1", IDLE, 1'b1, 1'b1, 1'b0);
    step("reset_hold2", IDLE, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    start = 1'b1;
    now_chk("idle_start", IDLE, 1'b1, 1'b1, 1'b0);
    step("idle_to_both", BOTH, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    step("start_drop", BOTH, 1'b0, 1'b0, 1'b0);

    // change walks BOTH -> SRC -> TAR -> SRC
    change = 1'b1;
    step("both_change", SRC, 1'b0, 1'b1, 1'b0);
    step("src_change", TAR, 1'b1, 1'b0, 1'b0);
    step("tar_change", SRC, 1'b0, 1'b1, 1'b0);
    align = 1'b1;
    step("align_over_change", BOTH, 1'b0, 1'b0, 1'b0);
    change = 1'b0;
    step("both_align_hold", BOTH, 1'b0, 1'b0, 1'b0);
    align  = 1'b0;
    change = 1'b1;
    step("enter_src", SRC, 1'b0, 1'b1, 1'b0);
    change = 1'b0;

`ifdef STUTTER_FAIRNESS_EN
    step("src_hold1", SRC, 1'b0, 1'b1, 1'b0);
    step("src_hold2", SRC, 1'b0, 1'b1, 1'b0);
    step("fair_src", BOTH, 1'b0, 1'b0, 1'b1);
    step("forced_one_cycle", BOTH, 1'b0, 1'b0, 1'b0);
    // A side swap restarts the stall budget
    change = 1'b1;
    step("enter_src2", SRC, 1'b0, 1'b1, 1'b0);
    change = 1'b0;
    step("src2_hold", SRC, 1'b0, 1'b1, 1'b0);
    change = 1'b1;
    step("swap_tar", TAR, 1'b1, 1'b0, 1'b0);
    change = 1'b0;
    step("tar_hold1", TAR, 1'b1, 1'b0, 1'b0);
    step("tar_hold2", TAR, 1'b1, 1'b0, 1'b0);
    step("fair_tar", BOTH, 1'b0, 1'b0, 1'b1);
`else
    for (int i = 0; i < 12; i++) begin
      step("src_persist", SRC, 1'b0, 1'b1, 1'b0);
    end
    align = 1'b1;
    step("align_back", BOTH, 1'b0, 1'b0, 1'b0);
    align = 1'b0;
`endif

    // Finish overrides and terminal DONE
    change = 1'b1;
    step("to_src", SRC, 1'b0, 1'b1, 1'b0);
    step("to_tar", TAR, 1'b1, 1'b0, 1'b0);
    change  = 1'b0;
    fin_tar = 1'b1;
    now_chk("fin_tar_override", TAR, 1'b1, 1'b1, 1'b0);
    step("tar_fin_hold", TAR, 1'b1, 1'b1, 1'b0);
    fin_src = 1'b1;
    now_chk("fin_src_override", TAR, 1'b1, 1'b1, 1'b0);
    step("to_done", DONE, 1'b1, 1'b1, 1'b0);
    change = 1'b1;
    align  = 1'b1;
    start  = 1'b1;
    step("done_sticky1", DONE, 1'b1, 1'b1, 1'b0);
    fin_src = 1'b0;
    fin_tar = 1'b0;
    step("done_sticky2", DONE, 1'b1, 1'b1, 1'b0);
    change = 1'b0;
    align  = 1'b0;
    start  = 1'b0;

    // Reset out of DONE
    rst_n = 1'b0;
    now_chk("reset_done", IDLE, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    start = 1'b1;
    step("restart", BOTH, 1'b0, 1'b0, 1'b0);
    start  = 1'b0;
    change = 1'b1;
    step("re_src", SRC, 1'b0, 1'b1, 1'b0);
    step("re_tar", TAR, 1'b1, 1'b0, 1'b0);
    change = 1'b0;
    step("tar_cnt1", TAR, 1'b1, 1'b0, 1'b0);
    step("tar_cnt2", TAR, 1'b1, 1'b0, 1'b0);

    // Reset pulse between edges while stalled in TAR_ONLY
    #2;
    rst_n = 1'b0;
    now_chk("reset_mid_tar", IDLE, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    start = 1'b1;
    now_chk("reset_release", IDLE, 1'b1, 1'b1, 1'b0);
    step("restart2", BOTH, 1'b0, 1'b0, 1'b0);
    start  = 1'b0;
    change = 1'b1;
    step("cnt_clear_src", SRC, 1'b0, 1'b1, 1'b0);
    change = 1'b0;
    step("cnt_clear_hold1", SRC, 1'b0, 1'b1, 1'b0);
    step("cnt_clear_hold2", SRC, 1'b0, 1'b1, 1'b0);
`ifdef STUTTER_FAIRNESS_EN
    step("cnt_clear_fair", BOTH, 1'b0, 1'b0, 1'b1);
`else
    step("cnt_clear_hold3", SRC, 1'b0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
